// File: rtl/pq_sched.sv
// Round-robin front end that serialises N clients' enqueue/dequeue requests onto a single
// max-first priority queue port, tracking occupancy and answering dequeues on empty locally.
module pq_sched #(
    parameter int unsigned N = 4,
    parameter int unsigned L = 3,
    parameter int unsigned W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         enq_valid,
    input  logic [N*W-1:0]       enq_value,
    output logic [N-1:0]         enq_ready,
    input  logic [N-1:0]         deq_req,
    output logic [N-1:0]         deq_gnt,
    output logic                 deq_resp_valid,
    output logic [$clog2(N)-1:0] deq_resp_id,
    output logic [W-1:0]         deq_resp_value,
    output logic                 deq_resp_empty,
    output logic [L-1:0]         count,
    output logic                 err,
    output logic                 pq_enq_valid,
    output logic [W-1:0]         pq_enq_value,
    input  logic                 pq_enq_ready,
    output logic                 pq_deq_req,
    input  logic [W-1:0]         pq_deq_value,
    input  logic                 pq_deq_valid
);

    localparam int unsigned S   = 2 * N;
    localparam int unsigned SW  = $clog2(S);
    localparam int unsigned IdW = $clog2(N);
    localparam int unsigned Cap = (1 << L) - 1;

    typedef enum logic {StIdle, StBusy} state_e;
    typedef enum logic [1:0] {OpEnq, OpDeq, OpEmpty} op_e;

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [SW-1:0]  rr_q, rr_d;
    logic [IdW-1:0] id_q, id_d;
    logic [L-1:0]   count_q, count_d;
    logic           err_q, err_d;
    logic           resp_valid_q, resp_valid_d;
    logic [IdW-1:0] resp_id_q, resp_id_d;
    logic [W-1:0]   resp_value_q, resp_value_d;
    logic           resp_empty_q, resp_empty_d;

    logic [S-1:0]   elig;
    logic           found;
    logic [SW-1:0]  win;
    logic [SW:0]    idx;
    logic           win_is_enq;
    logic [SW-1:0]  win_off;
    logic [IdW-1:0] win_id;

    // Slots 0..N-1 are enqueue requests, N..2N-1 are dequeue requests.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            elig[i]     = enq_valid[i] && (count_q != L'(Cap));
            elig[N + i] = deq_req[i];
        end
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < S; k++) begin
            idx = {1'b0, rr_q} + (SW + 1)'(k);
            if (idx >= (SW + 1)'(S)) begin
                idx = idx - (SW + 1)'(S);
            end
            if (!found && elig[idx[SW-1:0]]) begin
                found = 1'b1;
                win   = idx[SW-1:0];
            end
        end
    end

    assign win_is_enq = (win < SW'(N));
    assign win_off    = win_is_enq ? win : win - SW'(N);
    assign win_id     = win_off[IdW-1:0];

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rr_d         = rr_q;
        id_d         = id_q;
        count_d      = count_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_id_d    = '0;
        resp_value_d = '0;
        resp_empty_d = 1'b0;
        enq_ready    = '0;
        deq_gnt      = '0;
        pq_enq_valid = 1'b0;
        pq_enq_value = '0;
        pq_deq_req   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // An enqueue winner stalls the whole arbiter while the queue is not ready.
                if (!rst && found && (!win_is_enq || pq_enq_ready)) begin
                    if (win_is_enq) begin
                        enq_ready[win_id] = 1'b1;
                        pq_enq_valid      = 1'b1;
                        pq_enq_value      = enq_value[win_id*W +: W];
                        op_d              = OpEnq;
                    end else begin
                        deq_gnt[win_id] = 1'b1;
                        if (count_q != '0) begin
                            pq_deq_req = 1'b1;
                            op_d       = OpDeq;
                        end else begin
                            op_d = OpEmpty;
                        end
                    end
                    rr_d    = (win == SW'(S - 1)) ? '0 : win + SW'(1);
                    id_d    = win_id;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                state_d = StIdle;
                case (op_q)
                    OpEnq: count_d = count_q + L'(1);
                    OpDeq: begin
                        resp_valid_d = 1'b1;
                        resp_id_d    = id_q;
                        if (pq_deq_valid) begin
                            resp_value_d = pq_deq_value;
                            count_d      = count_q - L'(1);
                        end else begin
                            resp_empty_d = 1'b1;
                            err_d        = 1'b1;
                        end
                    end
                    OpEmpty: begin
                        resp_valid_d = 1'b1;
                        resp_id_d    = id_q;
                        resp_empty_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            op_q         <= OpEnq;
            rr_q         <= '0;
            id_q         <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_value_q <= '0;
            resp_empty_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rr_q         <= rr_d;
            id_q         <= id_d;
            count_q      <= count_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_value_q <= resp_value_d;
            resp_empty_q <= resp_empty_d;
        end
    end

    assign deq_resp_valid = resp_valid_q;
    assign deq_resp_id    = resp_id_q;
    assign deq_resp_value = resp_value_q;
    assign deq_resp_empty = resp_empty_q;
    assign count          = count_q;
    assign err            = err_q;

endmodule

// File: tb/tb_pq_sched.sv
// Directed bench for pq_sched with a behavioural max-first queue on the pq side and a
// response scoreboard filled with the expected dequeue results as stimulus is driven.
module tb_pq_sched;

    localparam int N = 4;
    localparam int L = 3;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   enq_valid;
    logic [N*W-1:0] enq_value;
    logic [N-1:0]   enq_ready;
    logic [N-1:0]   deq_req;
    logic [N-1:0]   deq_gnt;
    logic           deq_resp_valid;
    logic [1:0]     deq_resp_id;
    logic [W-1:0]   deq_resp_value;
    logic           deq_resp_empty;
    logic [L-1:0]   count;
    logic           err;
    logic           pq_enq_valid;
    logic [W-1:0]   pq_enq_value;
    logic           pq_enq_ready;
    logic           pq_deq_req;
    logic [W-1:0]   pq_deq_value;
    logic           pq_deq_valid;

    always #5 clk = ~clk;

    pq_sched #(.N(N), .L(L), .W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .enq_valid      (enq_valid),
        .enq_value      (enq_value),
        .enq_ready      (enq_ready),
        .deq_req        (deq_req),
        .deq_gnt        (deq_gnt),
        .deq_resp_valid (deq_resp_valid),
        .deq_resp_id    (deq_resp_id),
        .deq_resp_value (deq_resp_value),
        .deq_resp_empty (deq_resp_empty),
        .count          (count),
        .err            (err),
        .pq_enq_valid   (pq_enq_valid),
        .pq_enq_value   (pq_enq_value),
        .pq_enq_ready   (pq_enq_ready),
        .pq_deq_req     (pq_deq_req),
        .pq_deq_value   (pq_deq_value),
        .pq_deq_valid   (pq_deq_valid)
    );

    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] value;
        logic         empty;
    } resp_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          resp_cnt = 0;
    bit          saw_pq_deq = 1'b0;
    resp_t       exp_q[$];
    int          gnt_q[$];
    logic [W-1:0] pq_mem[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural max-first queue: answers a dequeue one cycle after the request.
    always @(posedge clk) begin : pq_model
        int mi;
        if (rst) begin
            pq_mem.delete();
            pq_deq_valid <= 1'b0;
            pq_deq_value <= '0;
        end else begin
            pq_deq_valid <= 1'b0;
            if (pq_enq_valid && pq_enq_ready) pq_mem.push_back(pq_enq_value);
            if (pq_deq_req && pq_mem.size() > 0) begin
                mi = 0;
                for (int i = 1; i < pq_mem.size(); i++) begin
                    if (pq_mem[i] > pq_mem[mi]) mi = i;
                end
                pq_deq_value <= pq_mem[mi];
                pq_deq_valid <= 1'b1;
                pq_mem.delete(mi);
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        resp_t e;
        if (rst) begin
            gnt_q.delete();
        end else begin
            if (deq_gnt != '0) gnt_q.push_back(cyc);
            if (pq_deq_req) saw_pq_deq = 1'b1;
            if (deq_resp_valid) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_id", deq_resp_id, e.id);
                    check("resp_value", deq_resp_value, e.value);
                    check("resp_empty", deq_resp_empty, e.empty);
                    check("resp_has_gnt", 64'(gnt_q.size() != 0), 64'd1);
                    if (gnt_q.size() != 0) check("resp_latency", 64'(cyc - gnt_q.pop_front()), 64'd2);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_resp(input int id, input logic [W-1:0] v, input logic e);
        resp_t r;
        r.id    = 2'(id);
        r.value = v;
        r.empty = e;
        exp_q.push_back(r);
    endtask

    task automatic do_enq(input int id, input logic [W-1:0] v);
        bit got;
        step();
        enq_valid[id]          = 1'b1;
        enq_value[id*W +: W]   = v;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (enq_ready[id]) begin
                got = 1'b1;
                break;
            end
        end
        check("enq_grant", enq_ready, 64'(1 << id));
        if (got) check("pq_enq_value", pq_enq_value, v);
        step();
        enq_valid[id] = 1'b0;
    endtask

    task automatic do_deq(input int id);
        step();
        deq_req[id] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (deq_gnt[id]) break;
        end
        check("deq_grant", deq_gnt, 64'(1 << id));
        step();
        deq_req[id] = 1'b0;
    endtask

    initial begin
        int rc;
        rst          = 1'b1;
        enq_valid    = '0;
        enq_value    = '0;
        deq_req      = '0;
        pq_enq_ready = 1'b1;

        // T1 reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_err", err, 0);
        check("rst_enq_ready", enq_ready, 0);
        check("rst_deq_gnt", deq_gnt, 0);
        check("rst_pq_enq_valid", pq_enq_valid, 0);
        check("rst_pq_deq_req", pq_deq_req, 0);
        check("rst_resp", {deq_resp_valid, deq_resp_empty, deq_resp_id, deq_resp_value}, 0);
        step();
        rst = 1'b0;

        // T2 single client
        do_enq(0, 32'h4);
        do_enq(0, 32'h44);
        do_enq(0, 32'h444);
        settle();
        check("t2_count_full3", count, 3);
        expect_resp(0, 32'h444, 1'b0);
        do_deq(0);
        expect_resp(0, 32'h44, 1'b0);
        do_deq(0);
        expect_resp(0, 32'h4, 1'b0);
        do_deq(0);
        settle();
        check("t2_count_zero", count, 0);

        // T3 fairness and full
        step();
        for (int i = 0; i < N; i++) enq_value[i*W +: W] = 32'h10 + 32'(i);
        enq_valid = '1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("t3_rr_grant", enq_ready, 64'(1 << (k % 4)));
            @(negedge clk);
            check("t3_busy_nogrant", enq_ready, 0);
        end
        repeat (4) begin
            @(negedge clk);
            check("t3_full_hold", enq_ready, 0);
        end
        check("t3_count_cap", count, 7);
        step();
        enq_valid = '0;
        expect_resp(3, 32'h13, 1'b0);
        expect_resp(3, 32'h12, 1'b0);
        expect_resp(3, 32'h12, 1'b0);
        expect_resp(3, 32'h11, 1'b0);
        expect_resp(3, 32'h11, 1'b0);
        expect_resp(3, 32'h10, 1'b0);
        expect_resp(3, 32'h10, 1'b0);
        repeat (7) do_deq(3);
        settle();
        check("t3_count_drained", count, 0);

        // T4 dequeue on empty
        saw_pq_deq = 1'b0;
        expect_resp(2, 32'h0, 1'b1);
        do_deq(2);
        settle();
        check("t4_no_pq_deq", saw_pq_deq, 0);
        check("t4_count", count, 0);
        check("t4_err", err, 0);

        // T5 mixed: leave {9,5} with rr_ptr back at 0
        do_enq(0, 32'h9);
        do_enq(0, 32'h5);
        do_enq(0, 32'h20);
        expect_resp(3, 32'h20, 1'b0);
        do_deq(3);
        settle();
        step();
        expect_resp(1, 32'h9, 1'b0);
        deq_req[1]         = 1'b1;
        enq_valid[3]       = 1'b1;
        enq_value[3*W +: W] = 32'h7;
        @(negedge clk);
        check("t5_enq_first", enq_ready, 4'b1000);
        check("t5_deq_waits", deq_gnt, 0);
        check("t5_pq_value", pq_enq_value, 32'h7);
        step();
        enq_valid[3] = 1'b0;
        @(negedge clk);
        check("t5_busy_gap", deq_gnt, 0);
        @(negedge clk);
        check("t5_deq_next", deq_gnt, 4'b0010);
        step();
        deq_req[1] = 1'b0;
        settle();
        check("t5_count", count, 2);

        // T6 reset while busy
        rc = resp_cnt;
        step();
        deq_req[0] = 1'b1;
        @(negedge clk);
        check("t6_deq_gnt", deq_gnt, 4'b0001);
        step();
        deq_req[0] = 1'b0;
        rst        = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check("t6_no_resp", resp_cnt, rc);
        check("t6_count", count, 0);
        check("t6_err", err, 0);

        pq_enq_ready = 1'b0;
        step();
        enq_valid[0]        = 1'b1;
        enq_value[0*W +: W] = 32'h55;
        repeat (2) begin
            @(negedge clk);
            check("t6_stall_ready", enq_ready, 0);
            check("t6_stall_pq", pq_enq_valid, 0);
        end
        step();
        pq_enq_ready = 1'b1;
        @(negedge clk);
        check("t6_enq_after_rst", enq_ready, 4'b0001);
        check("t6_pq_value", pq_enq_value, 32'h55);
        step();
        enq_valid[0] = 1'b0;
        settle();
        check("t6_count_one", count, 1);
        expect_resp(0, 32'h55, 1'b0);
        do_deq(0);
        settle();
        check("t6_count_final", count, 0);
        check("pending_resp", 64'(exp_q.size()), 0);
        check("final_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
